fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 36 +++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory handshake between the fetch stage and the instruction
//   memory. One request is a single-cycle ImemReq pulse carrying ImemAddr; the
//   memory answers later with a single-cycle ImemValid carrying ImemRdata.
//
//   Signals:
//     ImemReq    fetch -> mem   request pulse
//     ImemAddr   fetch -> mem   word-aligned byte address of the request
//     ImemRdata  mem -> fetch   instruction word being returned
//     ImemValid  mem -> fetch   ImemRdata is valid this cycle
//
//   Modports:
//     master  the fetch stage (issues requests)
//     slave   the instruction memory (answers requests)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemValid;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemRdata,
    input  ImemValid
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemRdata,
    output ImemValid
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch with a single outstanding memory request, a one-entry
//   skid buffer for words that return while decode is stalled, and redirect
//   handling for taken branches (execute) and PC writes (writeback).
//
//   Ports:
//     Clk            sole clock, rising edge
//     Rst            asynchronous active-low reset
//     StallF         hold IF/ID and the PC
//     FlushD         turn the IF/ID slot into a bubble
//     BranchTakenE   redirect to BranchTargetE
//     BranchTargetE  branch target address
//     PCSrcW         redirect to ResultW (wins over BranchTakenE)
//     ResultW        writeback PC value
//     imem           instruction-memory handshake (fetch_stage_if.master)
//     Instruction    IF/ID instruction word
//     PCPlus8D       fetch address of Instruction plus 8
//     ValidD         Instruction is real (0 = bubble)
//
//   ValidD is a one-cycle marker per delivered instruction: it is set when a
//   word enters IF/ID, held while StallF=1, and otherwise dropped back to 0 on
//   the next edge so decode never consumes the same word twice.
// -----------------------------------------------------------------------------
module fetch_stage (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          StallF,
  input  logic          FlushD,
  input  logic          BranchTakenE,
  input  logic [31:0]   BranchTargetE,
  input  logic          PCSrcW,
  input  logic [31:0]   ResultW,
  fetch_stage_if.master imem,
  output logic [31:0]   Instruction,
  output logic [31:0]   PCPlus8D,
  output logic          ValidD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetchStateT;

  fetchStateT  state, stateNext;

  logic [31:0] pc, pcNext;
  logic [31:0] fetchAddr, fetchAddrNext;   // address of the request in flight
  logic        kill, killNext;             // drop the next returned word
  logic [31:0] skidInstr, skidPcPlus8;
  logic        skidLoad;

  logic        ifidLoad;
  logic [31:0] ifidInstrNext;
  logic [31:0] ifidPcPlus8Next;

  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] reqAddr;

  // Writeback outranks execute. The mask keeps every PC value word aligned,
  // so sequential PC+4 never disturbs bits [1:0] either.
  assign redirect       = PCSrcW | BranchTakenE;
  assign redirectTarget = (PCSrcW ? ResultW : BranchTargetE) & 32'hFFFF_FFFC;

  // A redirect arriving in the request cycle steers that very request.
  assign reqAddr = redirect ? redirectTarget : pc;

  // NOTE: every signal written below gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    fetchAddrNext   = fetchAddr;
    killNext        = kill;
    skidLoad        = 1'b0;
    ifidLoad        = 1'b0;
    ifidInstrNext   = imem.ImemRdata;
    ifidPcPlus8Next = fetchAddr + 32'd8;
    imem.ImemReq    = 1'b0;
    imem.ImemAddr   = fetchAddr;

    unique case (state)
      IDLE: begin
        stateNext = REQ;
        if (redirect) pcNext = redirectTarget;
      end

      REQ: begin
        imem.ImemReq  = 1'b1;
        imem.ImemAddr = reqAddr;
        fetchAddrNext = reqAddr;
        pcNext        = reqAddr;
        stateNext     = WAIT;
      end

      WAIT: begin
        if (redirect) pcNext = redirectTarget;
        if (imem.ImemValid) begin
          stateNext = REQ;
          if (kill) begin
            // Word belongs to the abandoned path: discard it.
            killNext = 1'b0;
          end else if (!redirect) begin
            pcNext = pc + 32'd4;
            if (StallF) begin
              skidLoad  = 1'b1;
              stateNext = FULL;
            end else begin
              ifidLoad = 1'b1;
            end
          end
          // Redirect on the return cycle: word dropped, nothing left to kill.
        end else if (redirect) begin
          killNext = 1'b1;
        end
      end

      FULL: begin
        if (redirect) begin
          pcNext    = redirectTarget;
          stateNext = REQ;
        end else if (!StallF) begin
          ifidLoad        = 1'b1;
          ifidInstrNext   = skidInstr;
          ifidPcPlus8Next = skidPcPlus8;
          stateNext       = REQ;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= stateNext;
  end

  // NOTE: the skid buffer is reset along with everything else; it is a single
  // entry, and a defined value keeps outputs clean after a reset mid-fetch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc          <= 32'd0;
      fetchAddr   <= 32'd0;
      kill        <= 1'b0;
      skidInstr   <= 32'd0;
      skidPcPlus8 <= 32'd0;
      Instruction <= 32'd0;
      PCPlus8D    <= 32'd0;
      ValidD      <= 1'b0;
    end else begin
      pc        <= pcNext;
      fetchAddr <= fetchAddrNext;
      kill      <= killNext;

      if (skidLoad) begin
        skidInstr   <= imem.ImemRdata;
        skidPcPlus8 <= fetchAddr + 32'd8;
      end

      // Flush beats any load; stall holds; otherwise the slot empties.
      if (FlushD) begin
        Instruction <= 32'd0;
        ValidD      <= 1'b0;
      end else if (ifidLoad) begin
        Instruction <= ifidInstrNext;
        PCPlus8D    <= ifidPcPlus8Next;
        ValidD      <= 1'b1;
      end else if (!StallF) begin
        ValidD <= 1'b0;
      end
    end
  end

endmodule
